// File: rtl/multibyte_add_seq.sv
// Byte-serial wide adder controller: drives an external 8-bit adder one slice per
// clock (LSB first), chains the carry through a register, and publishes the full sum.
module multibyte_add_seq #(
  parameter  int NBYTES = 4,
  localparam int W      = 8 * NBYTES,
  localparam int IW     = $clog2(NBYTES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         overflow,
  output logic [7:0]   add_x,
  output logic [7:0]   add_y,
  output logic         add_cin,
  input  logic [7:0]   add_sum,
  input  logic         add_cout,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_t        state;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic          carry_r;
  logic [IW-1:0] idx;

  // Handshake: start is a request accepted on any rising edge where busy is low
  // (IDLE or DONE); while busy is high start is ignored. done is a one-cycle pulse
  // marking the cycle in which result/cout/overflow first show the new sum.
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

  // Accumulator with the current slice merged in, so the final byte reaches result
  // on the same edge it is captured.
  always_comb begin
    acc_next = acc;
    acc_next[{idx, 3'b000} +: 8] = add_sum;
  end

  always_comb begin
    add_x   = 8'd0;
    add_y   = 8'd0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_x   = a_r[{idx, 3'b000} +: 8];
      add_y   = b_r[{idx, 3'b000} +: 8];
      add_cin = carry_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      carry_r  <= 1'b0;
      idx      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx     <= '0;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc     <= acc_next;
          carry_r <= add_cout;
          idx     <= idx + 1'b1;
          if (idx == LAST) begin
            state    <= DONE;
            result   <= acc_next;
            cout     <= add_cout;
            overflow <= (a_r[W-1] == b_r[W-1]) && (add_sum[7] != a_r[W-1]);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed bench for multibyte_add_seq: a behavioural 8-bit adder closes the loop,
// a vector table covers arithmetic cases, hand sequences cover start/reset corners.
module tb_multibyte_add_seq;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic [7:0]   add_x;
  logic [7:0]   add_y;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;
  logic [1:0]   state_dbg;

  multibyte_add_seq #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  initial forever #5 clk = ~clk;

  // Stand-in for adder_8bit
  logic [8:0] adder_s;
  always_comb begin
    adder_s  = {1'b0, add_x} + {1'b0, add_y} + {8'd0, add_cin};
    add_sum  = adder_s[7:0];
    add_cout = adder_s[8];
  end

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int cyc_cnt  = 0;
  int last_done_cyc = 0;
  logic [W+1:0] exp_q[$];   // {cout, overflow, result}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_cnt++;

  // Scoreboard: every done pulse must match the oldest expected result
  logic [W+1:0] exp_e;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc_cnt;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("result",   64'(result),   64'(exp_e[W-1:0]));
        check("cout",     64'(cout),     64'(exp_e[W+1]));
        check("overflow", 64'(overflow), 64'(exp_e[W]));
      end
    end
  end

  // Driver tasks
  logic [7:0] byte0_x;
  logic       byte1_cin;

  task automatic run_vec(input vec_t v, input int id);
    int lat;
    int busy_cyc;
    lat = 0;
    busy_cyc = 0;
    @(posedge clk); #1;
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    exp_q.push_back({v.co, v.ov, v.res});
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) byte0_x = add_x;
      if (n == 2) byte1_cin = add_cin;
      if (busy) busy_cyc++;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) check($sformatf("timeout_vec%0d", id), 64'd0, 64'd1);
    check($sformatf("latency_vec%0d", id), 64'(lat), 64'(NBYTES + 1));
    check($sformatf("busy_cycles_vec%0d", id), 64'(busy_cyc), 64'(NBYTES));
  endtask

  task automatic wait_done(output int c, output bit ok);
    ok = 1'b0;
    c = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        c = cyc_cnt;
        break;
      end
    end
    if (!ok) check("timeout_wait_done", 64'd0, 64'd1);
  endtask

  vec_t vecs[8];
  int   d0;
  int   c1;
  int   c2;
  bit   ok;

  initial begin
    vecs[0] = '{a: 32'h0000000A, b: 32'h00000002, cin: 1'b0, res: 32'h0000000C, co: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 32'h000000FF, b: 32'h00000001, cin: 1'b0, res: 32'h00000100, co: 1'b0, ov: 1'b0};
    vecs[2] = '{a: 32'h00FFFFFF, b: 32'h00000001, cin: 1'b0, res: 32'h01000000, co: 1'b0, ov: 1'b0};
    vecs[3] = '{a: 32'hFFFFFFFF, b: 32'h00000000, cin: 1'b1, res: 32'h00000000, co: 1'b1, ov: 1'b0};
    vecs[4] = '{a: 32'h7FFFFFFF, b: 32'h00000001, cin: 1'b0, res: 32'h80000000, co: 1'b0, ov: 1'b1};
    vecs[5] = '{a: 32'h80000000, b: 32'h80000000, cin: 1'b0, res: 32'h00000000, co: 1'b1, ov: 1'b1};
    vecs[6] = '{a: 32'h12345678, b: 32'h11111111, cin: 1'b1, res: 32'h2345678A, co: 1'b0, ov: 1'b0};
    vecs[7] = '{a: 32'h7FFFFFFF, b: 32'h7FFFFFFF, cin: 1'b1, res: 32'hFFFFFFFF, co: 1'b0, ov: 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle outputs after reset
    @(negedge clk);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'({cout, overflow, busy, done}), 64'd0);
    check("reset_state", 64'(state_dbg), 64'd0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("idle_outputs_%0d", i), 64'({add_x, add_y, add_cin, busy, done}), 64'd0);
      @(negedge clk);
    end

    // Arithmetic table
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
      if (i == 0) check("byte0_add_x", 64'(byte0_x), 64'h0A);
      if (i == 0) check("byte1_cin_clear", 64'(byte1_cin), 64'd0);
      if (i == 1) check("byte1_cin_set", 64'(byte1_cin), 64'd1);
    end

    // start re-pulsed during RUN is ignored
    @(posedge clk); #1;
    d0 = done_cnt;
    a = 32'd1; b = 32'd1; cin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'h00000002});
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    a = 32'd5; b = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("single_done", 64'(done_cnt - d0), 64'd1);
    check("queue_empty_after_ignore", 64'(exp_q.size()), 64'd0);

    // start held high through DONE: back-to-back operations
    a = 32'd3; b = 32'd4; cin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'h00000007});
    exp_q.push_back({1'b0, 1'b0, 32'h00000007});
    wait_done(c1, ok);
    wait_done(c2, ok);
    start = 1'b0;
    check("b2b_spacing", 64'(c2 - c1), 64'(NBYTES + 1));
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty_after_b2b", 64'(exp_q.size()), 64'd0);
    check("idle_after_b2b", 64'(state_dbg), 64'd0);

    // Reset during the idx=2 cycle aborts the operation
    a = 32'h11111111; b = 32'h22222222; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("run_before_abort", 64'(state_dbg), 64'd1);
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_cout_ov", 64'({cout, overflow}), 64'd0);
    check("abort_state", 64'(state_dbg), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);

    run_vec('{a: 32'h11111111, b: 32'h22222222, cin: 1'b0, res: 32'h33333333, co: 1'b0, ov: 1'b0}, 8);
    repeat (2) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "global timeout");
  end

endmodule
